mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit that acts as the initiator on the data-memory port. It takes one load or store at a time from the core and splits it into a word-aligned memory request with byte enables. It then waits for the memory handshake and returns sign- or zero-extended load data, or a store acknowledge, to the core. It sits between the core's execute/memory stage and the data memory, and also detects misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 16: cycles allowed in REQ+WAIT before the access is aborted with error (2..255)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_valid  in  1  core presents an access; sampled only while cpu_ready=1
- cpu_ready  out  1  unit idle and able to accept (high iff state IDLE)
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_width  in  2  0=byte, 1=half, 2/3=word
- cpu_unsigned  in  1  zero-extend load (byte/half only)
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_done: misaligned or timeout
- cpu_rdata  out  32  extended load data, valid with cpu_done
- mem_req  out  1  request to memory
- mem_we  out  1  request is a write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data / write acknowledge valid
- mem_rdata  in  32  full read word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If cpu_valid=1, latch we/addr/wdata/width/unsigned.
  - If the access is misaligned (half with addr[0]=1; word with addr[1:0]≠0), go to RESP with the error flag set and issue no mem_req.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_we/addr/be/wdata are driven from the latched values and held stable until mem_gnt.
  - mem_gnt=1 and mem_rvalid=0: go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle: go straight to RESP.
- WAIT: mem_req=0; mem_rvalid=1 captures mem_rdata and goes to RESP.
- RESP: cpu_done=1 for exactly one cycle, then return to IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<(2·addr[1])
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data:
  - byte: lane = addr[1:0], sign-extended from bit 7 unless unsigned.
  - half: lane = addr[1], sign-extended from bit 15 unless unsigned.
  - word: passed through unchanged.
- Stores, error completions and timeouts return cpu_rdata=0.
- Timeout:
  - An 8-bit counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - If it reaches TIMEOUT-1 without completing, go to RESP with cpu_err=1, deassert mem_req, and ignore any late mem_rvalid.
- mem_rvalid arriving in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE, cpu_ready=1, cpu_done=0, cpu_err=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter 0.
- Reset mid-transaction: at the first rising edge with reset=1, all state returns to the reset values. An outstanding memory response after that is ignored.
- cpu_done, cpu_err and cpu_rdata are registered. cpu_rdata and cpu_err hold their value until the next cpu_done.
- Latency, counted from the accept edge N (IDLE with cpu_valid=1):
  - REQ is active in cycle N+1.
  - With gnt and rvalid both in N+1, cpu_done is in cycle N+2 (minimum 2 cycles).
  - Each wait cycle in REQ or WAIT adds 1.
  - A misaligned access gives cpu_done in cycle N+1, with mem_req never asserted.
- cpu_ready is low from N+1 until the cycle after cpu_done. A new access is earliest 1 cycle after the done pulse.
- Exactly one outstanding memory request at a time.

## Test plan
- Signed byte load, addr 0x103, mem_rdata 0x80FF1234 → mem_addr 0x100, mem_be 4'b1000, cpu_rdata 0xFFFFFF80. Same access with cpu_unsigned=1 → 0x00000080.
- Half store, addr 0x22, wdata 0x1234ABCD, gnt+rvalid together → mem_addr 0x20, mem_be 4'b1100, mem_wdata 0xABCDABCD, cpu_done exactly 2 cycles after accept, cpu_err=0.
- Word load, addr 0x06 → mem_req stays 0, cpu_done+cpu_err at N+1, cpu_rdata 0. Half load at 0x05 → same.
- TIMEOUT=4, mem_gnt held 0 → cpu_done with cpu_err=1 after 4 cycles in REQ, mem_req drops. A later mem_rvalid=1 in IDLE → no cpu_done.
- Load at 0x40, mem_gnt in cycle 1, reset=1 while in WAIT, then mem_rvalid=1 → all outputs at reset values, no cpu_done, cpu_ready=1.
- Back-to-back: word store 0x10 then word load 0x10 with cpu_valid held high → second accept one cycle after the first cpu_done, mem_be 4'b1111 for both.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: turns one core load/store at a time into a word-aligned memory
// request with byte enables, then returns extended load data or a store acknowledge.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_unsigned,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              lat_we, lat_we_nxt;
    logic [1:0]        lat_off, lat_off_nxt;
    logic [1:0]        lat_width, lat_width_nxt;
    logic              lat_uns, lat_uns_nxt;

    logic              cpu_ready_nxt, cpu_done_nxt, cpu_err_nxt;
    logic [31:0]       cpu_rdata_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [31:0]       mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]        mem_be_nxt;

    logic              misaligned_c;
    logic [31:0]       load_data_c;

    // Select the addressed lane of a read word and sign/zero extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  width,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            2'd0:    extend_load = {{24{b[7] & ~uns}}, b};
            2'd1:    extend_load = {{16{h[15] & ~uns}}, h};
            default: extend_load = word;
        endcase
    endfunction

    assign misaligned_c = ((cpu_width == 2'd1) && cpu_addr[0]) ||
                          (cpu_width[1] && (cpu_addr[1:0] != 2'b00));
    assign load_data_c  = lat_we ? 32'd0 : extend_load(mem_rdata, lat_off, lat_width, lat_uns);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_off   <= 2'b00;
            lat_width <= 2'b00;
            lat_uns   <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_we    <= lat_we_nxt;
            lat_off   <= lat_off_nxt;
            lat_width <= lat_width_nxt;
            lat_uns   <= lat_uns_nxt;
            cpu_ready <= cpu_ready_nxt;
            cpu_done  <= cpu_done_nxt;
            cpu_err   <= cpu_err_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_be    <= mem_be_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    // Next state and next registered outputs; completion wins over timeout.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_we_nxt    = lat_we;
        lat_off_nxt   = lat_off;
        lat_width_nxt = lat_width;
        lat_uns_nxt   = lat_uns;
        cpu_done_nxt  = 1'b0;
        cpu_err_nxt   = cpu_err;
        cpu_rdata_nxt = cpu_rdata;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_be_nxt    = mem_be;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (cpu_valid) begin
                    lat_we_nxt    = cpu_we;
                    lat_off_nxt   = cpu_addr[1:0];
                    lat_width_nxt = cpu_width;
                    lat_uns_nxt   = cpu_unsigned;
                    if (misaligned_c) begin
                        state_nxt     = RESP;
                        cpu_done_nxt  = 1'b1;
                        cpu_err_nxt   = 1'b1;
                        cpu_rdata_nxt = '0;
                    end else begin
                        state_nxt    = REQ;
                        cnt_nxt      = '0;
                        mem_req_nxt  = 1'b1;
                        mem_we_nxt   = cpu_we;
                        mem_addr_nxt = {cpu_addr[31:2], 2'b00};
                        case (cpu_width)
                            2'd0: begin
                                mem_be_nxt    = 4'b0001 << cpu_addr[1:0];
                                mem_wdata_nxt = {4{cpu_wdata[7:0]}};
                            end
                            2'd1: begin
                                mem_be_nxt    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                                mem_wdata_nxt = {2{cpu_wdata[15:0]}};
                            end
                            default: begin
                                mem_be_nxt    = 4'b1111;
                                mem_wdata_nxt = cpu_wdata;
                            end
                        endcase
                    end
                end
            end
            REQ: begin
                cnt_nxt = CNT_W'(cnt + 1'b1);
                if (mem_gnt && mem_rvalid) begin
                    state_nxt     = RESP;
                    cpu_done_nxt  = 1'b1;
                    cpu_err_nxt   = 1'b0;
                    cpu_rdata_nxt = load_data_c;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = RESP;
                    cpu_done_nxt  = 1'b1;
                    cpu_err_nxt   = 1'b1;
                    cpu_rdata_nxt = '0;
                end else if (mem_gnt) begin
                    state_nxt = WAIT;
                end else begin
                    mem_req_nxt = 1'b1;
                end
            end
            WAIT: begin
                cnt_nxt = CNT_W'(cnt + 1'b1);
                if (mem_rvalid) begin
                    state_nxt     = RESP;
                    cpu_done_nxt  = 1'b1;
                    cpu_err_nxt   = 1'b0;
                    cpu_rdata_nxt = load_data_c;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = RESP;
                    cpu_done_nxt  = 1'b1;
                    cpu_err_nxt   = 1'b1;
                    cpu_rdata_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        cpu_ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads/stores, misalignment, wait state, timeout,
// reset mid-transaction and back-to-back accesses against hand-computed values.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready, cpu_we, cpu_unsigned;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_width;
    logic        cpu_done, cpu_err;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int vectors = 0;
    int miscompares = 0;

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
        .cpu_unsigned(cpu_unsigned), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] width, input logic uns);
        cpu_valid    = 1'b1;
        cpu_we       = we;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        cpu_width    = width;
        cpu_unsigned = uns;
    endtask

    task automatic mem_drive(input logic g, input logic r, input logic [31:0] d);
        mem_gnt    = g;
        mem_rvalid = r;
        mem_rdata  = d;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        check({tag, "_done"},  32'(cpu_done),  32'd0);
        check({tag, "_err"},   32'(cpu_err),   32'd0);
        check({tag, "_rdata"}, cpu_rdata,      32'd0);
        check({tag, "_req"},   32'(mem_req),   32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  mem_addr,       32'd0);
        check({tag, "_be"},    32'(mem_be),    32'd0);
        check({tag, "_wdata"}, mem_wdata,      32'd0);
    endtask

    // Aligned byte load with same-cycle gnt+rvalid; returns after the done cycle.
    task automatic byte_load(input logic uns, input logic [31:0] exp_rdata, input string tag);
        present(1'b0, 32'h103, 32'h0, 2'd0, uns);
        tick();
        cpu_valid = 1'b0;
        check({tag, "_req"},   32'(mem_req),   32'd1);
        check({tag, "_addr"},  mem_addr,       32'h100);
        check({tag, "_be"},    32'(mem_be),    32'h8);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd0);
        mem_drive(1'b1, 1'b1, 32'h80FF1234);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check({tag, "_done"},  32'(cpu_done),  32'd1);
        check({tag, "_err"},   32'(cpu_err),   32'd0);
        check({tag, "_rdata"}, cpu_rdata,      exp_rdata);
        tick();
        check({tag, "_done_off"}, 32'(cpu_done),  32'd0);
        check({tag, "_ready_on"}, 32'(cpu_ready), 32'd1);
    endtask

    task automatic misaligned_load(input logic [31:0] addr, input logic [1:0] width, input string tag);
        present(1'b0, addr, 32'h0, width, 1'b0);
        tick();
        cpu_valid = 1'b0;
        check({tag, "_req"},   32'(mem_req),  32'd0);
        check({tag, "_done"},  32'(cpu_done), 32'd1);
        check({tag, "_err"},   32'(cpu_err),  32'd1);
        check({tag, "_rdata"}, cpu_rdata,     32'd0);
        tick();
        check({tag, "_req2"},  32'(mem_req),   32'd0);
        check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_width = 2'd0; cpu_unsigned = 1'b0;
        mem_drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("rst");

        byte_load(1'b0, 32'hFFFFFF80, "lb_s");
        misaligned_load(32'h06, 2'd2, "lw_mis");
        byte_load(1'b1, 32'h00000080, "lb_u");
        misaligned_load(32'h05, 2'd1, "lh_mis");

        // Half store, grant and ack together: done exactly two cycles after accept.
        present(1'b1, 32'h22, 32'h1234ABCD, 2'd1, 1'b0);
        tick();
        cpu_valid = 1'b0;
        check("sh_req",   32'(mem_req), 32'd1);
        check("sh_we",    32'(mem_we),  32'd1);
        check("sh_addr",  mem_addr,     32'h20);
        check("sh_be",    32'(mem_be),  32'hC);
        check("sh_wdata", mem_wdata,    32'hABCDABCD);
        check("sh_done_n1", 32'(cpu_done), 32'd0);
        mem_drive(1'b1, 1'b1, 32'h55555555);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("sh_done",  32'(cpu_done), 32'd1);
        check("sh_err",   32'(cpu_err),  32'd0);
        check("sh_rdata", cpu_rdata,     32'd0);
        tick();

        // Signed half load through one WAIT cycle.
        present(1'b0, 32'h42, 32'h0, 2'd1, 1'b0);
        tick();
        cpu_valid = 1'b0;
        check("lh_be", 32'(mem_be), 32'hC);
        mem_drive(1'b1, 1'b0, 32'h0);
        tick();
        mem_drive(1'b0, 1'b1, 32'h80017FFF);
        check("lh_req_wait", 32'(mem_req),  32'd0);
        check("lh_done_n2",  32'(cpu_done), 32'd0);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("lh_done",  32'(cpu_done), 32'd1);
        check("lh_rdata", cpu_rdata,     32'hFFFF8001);
        tick();

        // Timeout with grant held low, then a stray rvalid in IDLE.
        present(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        tick();
        cpu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to_req_hold", 32'(mem_req),  32'd1);
            check("to_no_done",  32'(cpu_done), 32'd0);
            tick();
        end
        check("to_req_last", 32'(mem_req), 32'd1);
        tick();
        check("to_done",  32'(cpu_done), 32'd1);
        check("to_err",   32'(cpu_err),  32'd1);
        check("to_req",   32'(mem_req),  32'd0);
        check("to_rdata", cpu_rdata,     32'd0);
        tick();
        mem_drive(1'b0, 1'b1, 32'h12345678);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("late_rv_done",  32'(cpu_done),  32'd0);
        check("late_rv_ready", 32'(cpu_ready), 32'd1);
        check("late_rv_err",   32'(cpu_err),   32'd1);

        // Reset while in WAIT; the late response must be ignored.
        present(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        tick();
        cpu_valid = 1'b0;
        mem_drive(1'b1, 1'b0, 32'h0);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("rst_wait");
        mem_drive(1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("rst_late_done",  32'(cpu_done),  32'd0);
        check("rst_late_ready", 32'(cpu_ready), 32'd1);
        check("rst_late_rdata", cpu_rdata,      32'd0);

        // Back-to-back word store then word load with cpu_valid held high.
        present(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
        tick();
        check("b2b_st_be",    32'(mem_be), 32'hF);
        check("b2b_st_we",    32'(mem_we), 32'd1);
        check("b2b_st_wdata", mem_wdata,    32'hDEADBEEF);
        cpu_we = 1'b0;
        mem_drive(1'b1, 1'b1, 32'h0);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("b2b_st_done",  32'(cpu_done),  32'd1);
        check("b2b_st_ready", 32'(cpu_ready), 32'd0);
        tick();
        check("b2b_idle_ready", 32'(cpu_ready), 32'd1);
        tick();
        cpu_valid = 1'b0;
        check("b2b_ld_req",  32'(mem_req),  32'd1);
        check("b2b_ld_we",   32'(mem_we),   32'd0);
        check("b2b_ld_be",   32'(mem_be),   32'hF);
        check("b2b_ld_addr", mem_addr,      32'h10);
        mem_drive(1'b1, 1'b1, 32'hCAFEF00D);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0);
        check("b2b_ld_done",  32'(cpu_done), 32'd1);
        check("b2b_ld_rdata", cpu_rdata,     32'hCAFEF00D);
        tick();
        check("b2b_ld_rdata_hold", cpu_rdata, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
